// File: rtl/clint_axi.sv
// rtl/clint_axi.sv - AXI4 single-beat slave holding the mtime/mtimecmp timer and timer interrupt
module clint_axi #(
    parameter logic [31:0] BASE     = 32'h0200_0000,
    parameter int          TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    output logic [3:0]  bid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    output logic [3:0]  rid,
    input  logic        rready,
    output logic        timer_irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [0:0] {R_IDLE, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wstate_t;

    // Only the four aligned words at offsets 0x0..0xC exist, and only single beats
    function automatic logic reg_ok(input logic [15:0] ofs, input logic [7:0] len);
        return (ofs[15:4] == 12'h000) && (ofs[1:0] == 2'b00) && (len == 8'd0);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wr_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wr_word[8*i +: 8];
        end
        return res;
    endfunction

    // Width/burst attributes and the upper address bits are decided by the crossbar
    logic unused_ok;
    assign unused_ok = ^{awsize, awburst, wlast, arsize, arburst, awaddr[31:16], araddr[31:16]};

    logic [63:0]   mtime, mtimecmp;
    logic [63:0]   mtime_inc, mtime_nxt, mtimecmp_nxt;
    logic [PW-1:0] presc;
    logic          tick;

    rstate_t       rstate;
    wstate_t       wstate;

    logic [15:0]   ar_ofs;
    logic [31:0]   rd_val;

    logic [15:0]   aw_ofs_q;
    logic [7:0]    aw_len_q;
    logic [3:0]    aw_id_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;

    logic          aw_hs, w_hs, have_aw, have_w, wr_commit, wr_ok;
    logic [15:0]   wr_ofs;
    logic [7:0]    wr_len;
    logic [3:0]    wr_id;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;

    assign arready = (rstate == R_IDLE);
    assign awready = (wstate == W_IDLE) || (wstate == W_GOT_W);
    assign wready  = (wstate == W_IDLE) || (wstate == W_GOT_AW);
    assign rlast   = rvalid;

    assign tick    = (presc == PRESC_MAX);
    assign ar_ofs  = araddr[15:0] - BASE[15:0];

    // A channel counts as present either from this cycle's handshake or from its latch
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign have_aw   = aw_hs || (wstate == W_GOT_AW);
    assign have_w    = w_hs || (wstate == W_GOT_W);
    assign wr_commit = have_aw && have_w;
    assign wr_ofs    = aw_hs ? (awaddr[15:0] - BASE[15:0]) : aw_ofs_q;
    assign wr_len    = aw_hs ? awlen : aw_len_q;
    assign wr_id     = aw_hs ? awid : aw_id_q;
    assign wr_data   = w_hs ? wdata : w_data_q;
    assign wr_strb   = w_hs ? wstrb : w_strb_q;
    assign wr_ok     = reg_ok(wr_ofs, wr_len);

    // Next timer state: written bytes override, unwritten mtime bytes take the ticked value
    always_comb begin
        mtime_inc    = mtime + {63'd0, tick};
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = mtimecmp;
        if (wr_commit && wr_ok) begin
            case (wr_ofs[3:2])
                2'd0:    mtime_nxt[31:0]     = merge_bytes(mtime_inc[31:0],  wr_data, wr_strb);
                2'd1:    mtime_nxt[63:32]    = merge_bytes(mtime_inc[63:32], wr_data, wr_strb);
                2'd2:    mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0],  wr_data, wr_strb);
                default: mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], wr_data, wr_strb);
            endcase
        end
    end

    // Read data selection from the current (pre-write) register contents
    always_comb begin
        rd_val = 32'd0;
        case (ar_ofs[3:2])
            2'd0:    rd_val = mtime[31:0];
            2'd1:    rd_val = mtime[63:32];
            2'd2:    rd_val = mtimecmp[31:0];
            default: rd_val = mtimecmp[63:32];
        endcase
    end

    // Timer registers, prescaler and the registered compare output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc     <= '0;
            timer_irq <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= mtimecmp_nxt;
            presc     <= tick ? '0 : presc + 1'b1;
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    // Read FSM: accept one address, hold the response until the master takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate <= R_IDLE;
            rvalid <= 1'b0;
            rdata  <= 32'd0;
            rresp  <= RESP_OKAY;
            rid    <= 4'd0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rstate <= R_RESP;
                        rvalid <= 1'b1;
                        rid    <= arid;
                        if (reg_ok(ar_ofs, arlen)) begin
                            rdata <= rd_val;
                            rresp <= RESP_OKAY;
                        end else begin
                            rdata <= 32'd0;
                            rresp <= RESP_SLVERR;
                        end
                    end
                end
                default: begin
                    if (rready) begin
                        rstate <= R_IDLE;
                        rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Write FSM: latch AW and W independently, commit once both are held, then respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate   <= W_IDLE;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            bid      <= 4'd0;
            aw_ofs_q <= 16'd0;
            aw_len_q <= 8'd0;
            aw_id_q  <= 4'd0;
            w_data_q <= 32'd0;
            w_strb_q <= 4'd0;
        end else begin
            if (aw_hs) begin
                aw_ofs_q <= awaddr[15:0] - BASE[15:0];
                aw_len_q <= awlen;
                aw_id_q  <= awid;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            case (wstate)
                W_RESP: begin
                    if (bready) begin
                        wstate <= W_IDLE;
                        bvalid <= 1'b0;
                    end
                end
                default: begin
                    if (wr_commit) begin
                        wstate <= W_RESP;
                        bvalid <= 1'b1;
                        bid    <= wr_id;
                        bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end else if (have_aw) begin
                        wstate <= W_GOT_AW;
                    end else if (have_w) begin
                        wstate <= W_GOT_W;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_axi.sv
// tb/tb_clint_axi.sv - directed self-checking bench for clint_axi (TICK_DIV 1 and 4 side by side)
module tb_clint_axi;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;

    logic        awready, wready, bvalid, arready, rvalid, rlast, timer_irq;
    logic [1:0]  bresp, rresp;
    logic [3:0]  bid, rid;
    logic [31:0] rdata;

    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, rlast_b, timer_irq_b;
    logic [1:0]  bresp_b, rresp_b;
    logic [3:0]  bid_b, rid_b;
    logic [31:0] rdata_b;

    int          n_checks;
    int          n_fail;
    int          cyc;

    logic [31:0] r_data, r_data_b;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;
    logic        r_last;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        b_irq;
    int          b_cyc;

    clint_axi #(.BASE(32'h0200_0000), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rid(rid), .rready(rready),
        .timer_irq(timer_irq)
    );

    clint_axi #(.BASE(32'h0200_0000), .TICK_DIV(4)) dut_div4 (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_b), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bid(bid_b), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_b), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rlast(rlast_b), .rid(rid_b), .rready(rready),
        .timer_irq(timer_irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: first edge after release is cycle 1
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts and ends on a negedge; rready is expected to be high
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int t;
        araddr  = addr;
        arid    = id;
        arlen   = len;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rvalid_seen", rvalid, 1);
        r_data   = rdata;
        r_resp   = rresp;
        r_id     = rid;
        r_last   = rlast;
        r_data_b = rdata_b;
        @(negedge clk);
    endtask

    // order: 0 = AW and W together, 1 = AW one cycle before W, 2 = W two cycles before AW
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input logic [7:0] len, input int order);
        int t;
        awaddr = addr;
        awid   = id;
        awlen  = len;
        wdata  = data;
        wstrb  = strb;
        if (order == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            @(negedge clk);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else if (order == 1) begin
            awvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0;
            wvalid  = 1'b1;
            @(negedge clk);
            wvalid  = 1'b0;
        end else begin
            wvalid = 1'b1;
            @(negedge clk);
            wvalid = 1'b0;
            @(negedge clk);
            awvalid = 1'b1;
            @(negedge clk);
            awvalid = 1'b0;
        end
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bvalid_seen", bvalid, 1);
        b_resp = bresp;
        b_id   = bid;
        b_irq  = timer_irq;
        b_cyc  = cyc;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int c1;
        int t1;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        awaddr = 0; awvalid = 0; awid = 0; awlen = 0; awsize = 3'd2; awburst = 2'd1;
        wdata = 0; wstrb = 0; wlast = 1'b1; wvalid = 0; bready = 1'b1;
        araddr = 0; arvalid = 0; arid = 0; arlen = 0; arsize = 3'd2; arburst = 2'd1;
        rready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", timer_irq, 0);
        check("rst_arready_div4", arready_b, 1);

        // Free-running count: ten idle cycles then read mtime lo
        rst = 1'b1;
        repeat (10) @(negedge clk);
        do_read(32'h0200_0000, 4'h3, 8'd0);
        check("mtime_lo_after_10", r_data, 32'd10);
        check("mtime_lo_rresp", r_resp, 2'b00);
        check("mtime_lo_rlast", r_last, 1);
        check("mtime_lo_rid", r_id, 4'h3);

        // W leads AW by two cycles
        do_write(32'h0200_0004, 32'h1, 4'hF, 4'h5, 8'd0, 2);
        check("whi_bresp", b_resp, 2'b00);
        check("whi_bid", b_id, 4'h5);
        check("whi_single_b", bvalid, 0);
        do_read(32'h0200_0004, 4'h1, 8'd0);
        check("mtime_hi_rd", r_data, 32'h1);

        // Interrupt timing against mtimecmp = 20
        do_write(32'h0200_0004, 32'h0, 4'hF, 4'h1, 8'd0, 0);
        do_write(32'h0200_0000, 32'h0, 4'hF, 4'h1, 8'd0, 0);
        c0 = b_cyc;
        do_write(32'h0200_0008, 32'd20, 4'hF, 4'h2, 8'd0, 0);
        do_write(32'h0200_000C, 32'h0, 4'hF, 4'h2, 8'd0, 1);
        while (cyc < c0 + 20) @(negedge clk);
        check("irq_before_20", timer_irq, 0);
        @(negedge clk);
        check("irq_at_20", timer_irq, 1);
        repeat (5) @(negedge clk);
        check("irq_stays", timer_irq, 1);
        do_write(32'h0200_000C, 32'hFFFF_FFFF, 4'hF, 4'h4, 8'd0, 1);
        check("irq_at_cmp_commit", b_irq, 1);
        check("irq_falls", timer_irq, 0);

        // Error responses leave state untouched
        do_read(32'h0200_0010, 4'h6, 8'd0);
        check("unmapped_rresp", r_resp, 2'b10);
        check("unmapped_rdata", r_data, 32'd0);
        do_read(32'h0200_0002, 4'h6, 8'd0);
        check("misalign_rresp", r_resp, 2'b10);
        check("misalign_rdata", r_data, 32'd0);
        do_read(32'h0200_0008, 4'h6, 8'd1);
        check("arlen_rresp", r_resp, 2'b10);
        check("arlen_rdata", r_data, 32'd0);
        do_write(32'h0200_000C, 32'h0, 4'hF, 4'h7, 8'd1, 0);
        check("awlen_bresp", b_resp, 2'b10);
        check("awlen_bid", b_id, 4'h7);
        repeat (3) @(negedge clk);
        check("awlen_irq", timer_irq, 0);
        do_read(32'h0200_000C, 4'h6, 8'd0);
        check("cmp_hi_kept", r_data, 32'hFFFF_FFFF);
        check("cmp_hi_rresp", r_resp, 2'b00);

        // Concurrent read and write with both responses back-pressured
        rready  = 1'b0;
        bready  = 1'b0;
        araddr  = 32'h0200_0008; arid = 4'h9; arlen = 0; arvalid = 1'b1;
        awaddr  = 32'h0200_0008; awid = 4'hA; awlen = 0; awvalid = 1'b1;
        wdata   = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata_prewrite", rdata, 32'd20);
            check("hold_rid", rid, 4'h9);
            check("hold_bvalid", bvalid, 1);
            check("hold_bresp", bresp, 2'b00);
            check("hold_bid", bid, 4'hA);
            check("hold_arready", arready, 0);
            check("hold_awready", awready, 0);
            check("hold_wready", wready, 0);
            @(negedge clk);
        end
        rready = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        check("release_rvalid", rvalid, 0);
        check("release_bvalid", bvalid, 0);
        check("release_arready", arready, 1);
        check("release_awready", awready, 1);
        do_read(32'h0200_0008, 4'h0, 8'd0);
        check("cmp_lo_new", r_data, 32'h55);
        do_write(32'h0200_0008, 32'h0000_AA00, 4'b0010, 4'h3, 8'd0, 0);
        do_read(32'h0200_0008, 4'h0, 8'd0);
        check("cmp_lo_strb", r_data, 32'h0000_AA55);

        // Carry into mtime hi on the divide-by-4 instance
        do_write(32'h0200_0004, 32'h0, 4'hF, 4'h1, 8'd0, 0);
        do_write(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, 4'h1, 8'd0, 0);
        c1 = b_cyc;
        t1 = (c1 / 4 + 1) * 4;
        while (cyc < t1) @(negedge clk);
        do_read(32'h0200_0000, 4'h2, 8'd0);
        check("div4_lo_carry", r_data_b, 32'h0);
        do_read(32'h0200_0004, 4'h2, 8'd0);
        check("div4_hi_carry", r_data_b, 32'h1);

        // Reset while a read response is pending
        rready  = 1'b0;
        araddr  = 32'h0200_0000; arid = 4'hC; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("pre_rst_rvalid", rvalid, 1);
        check("pre_rst_rvalid_div4", rvalid_b, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_arready", arready, 1);
        check("mid_rst_rvalid_div4", rvalid_b, 0);
        check("mid_rst_arready_div4", arready_b, 1);
        @(negedge clk);
        rst    = 1'b1;
        rready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_resp", rvalid, 0);
        check("post_rst_irq", timer_irq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_axi.md
Name: clint_axi

Overview:
- AXI4 slave that the crossbar routes to for addresses 0x0200_0000–0x0200_ffff.
- Holds a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register, both readable and writable as 32-bit words.
- Drives a registered timer interrupt to the core.
- Supports single-beat transactions only; read and write channels run independently.

Parameters:
- BASE, 32'h0200_0000, base address; only addr[15:0] are decoded.
- TICK_DIV, 1, mtime increments once every TICK_DIV clocks (legal range ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awid  in  4  write id.
- awlen  in  8  burst length; must be 0.
- awsize  in  3  unused.
- awburst  in  2  unused.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  unused.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bid  out  4  latched awid.
- bready  in  1  write response ready.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- arid  in  4  read id.
- arlen  in  8  burst length; must be 0.
- arsize  in  3  unused.
- arburst  in  2  unused.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rlast  out  1  last beat; always 1 whenever rvalid=1.
- rid  out  4  latched arid.
- rready  in  1  read data ready.
- timer_irq  out  1  registered (mtime >= mtimecmp).

Behaviour:
- Register map (offset = addr[15:0]):
  - 0x0 = mtime[31:0]; 0x4 = mtime[63:32].
  - 0x8 = mtimecmp[31:0]; 0xC = mtimecmp[63:32].
  - Any other offset is unmapped.
- Reset (rst=0, async):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0.
  - Read FSM = R_IDLE, write FSM = W_IDLE.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, rid=0, bid=0, timer_irq=0.
  - arready=1, awready=1, wready=1.
  - Reset mid-transaction drops the transaction; no response is issued.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - mtime += 1 (64-bit wrap) on the cycle the prescaler equals TICK_DIV-1; prescaler then returns to 0.
  - Register writes do not touch the prescaler.
- Read FSM (R_IDLE, R_RESP):
  - arready = (state == R_IDLE).
  - On arvalid&&arready: latch arid→rid; sample the register value into rdata; go to R_RESP.
    - rresp=SLVERR (2'b10) and rdata=0 if the offset is unmapped, addr[1:0]≠0, or arlen≠0.
    - Otherwise rresp=OKAY.
  - R_RESP: rvalid=1, rlast=1. rdata, rresp and rid hold stable until rvalid&&rready, then return to R_IDLE.
  - Minimum latency: 1 cycle from AR handshake to rvalid.
- Write FSM (W_IDLE, W_GOT_AW, W_GOT_W, W_RESP):
  - awready = state ∈ {W_IDLE, W_GOT_W}; wready = state ∈ {W_IDLE, W_GOT_AW}.
  - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - When both are held, the commit happens on that clock edge; then go to W_RESP with bvalid=1 and bid=latched awid.
  - Commit rules:
    - Mapped, aligned, awlen=0: each byte i with wstrb[i]=1 updates the addressed word; bresp=OKAY.
    - Otherwise: no state change; bresp=SLVERR.
  - W_RESP holds until bvalid&&bready, then returns to W_IDLE.
  - No new AW or W is accepted while in W_RESP.
- Simultaneous events:
  - A write commit to an mtime word in the same cycle as a tick: the written bytes take the written value and unwritten bytes take the incremented value.
  - A read sampled in the same cycle as a write commit returns the pre-write value.
  - The read and write FSMs never block each other.
- timer_irq: registered each cycle from the current mtime/mtimecmp, i.e. it reflects the previous cycle's comparison (1-cycle lag).
- Hi/lo words are not atomic; software reads hi–lo–hi.

Test Plan:
- Reset, TICK_DIV=1, idle 10 cycles, then read 0x0200_0000 → rdata=10±1 (per latency), rresp=OKAY, rlast=1, rid=arid.
- Write 0x0200_0004 data 0x1 with wstrb 4'hF, W before AW by 2 cycles → single bvalid with bresp=OKAY, bid=awid; subsequent hi read → 0x1.
- Write mtimecmp lo=20, hi=0 (mtimecmp was all-ones) → timer_irq rises exactly 1 cycle after mtime reaches 20 and stays 1; rewriting hi=0xFFFF_FFFF → timer_irq falls next cycle.
- Read 0x0200_0010, read 0x0200_0002, write with awlen=1 → SLVERR each, rdata=0, no register change.
- Concurrent read and write with rready/bready held low 5 cycles → rvalid/bvalid and their data stay stable, arready/awready stay 0 until the handshake.
- TICK_DIV=4: write mtime lo=0xFFFF_FFFF, hi=0 → after 4 cycles read hi=1, lo=0 (carry); assert rst mid-R_RESP → rvalid drops immediately, arready=1.
